// File: rtl/line_mem_resp_pkg.sv
// Shared definitions for the cache-line memory responder and its users.
// Holds the FSM state encoding, default line geometry shared with the data
// cache, and the word-to-line address conversion constant.
package line_mem_resp_pkg;

    localparam int LINE_W_DEF = 128;
    localparam int ADDR_W_DEF = 8;
    localparam int OFFSET_W   = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WBUSY = 3'd1,
        RBUSY = 3'd2,
        WHOLD = 3'd3,
        RHOLD = 3'd4
    } state_t;

    // Word address to line address: drop the word-in-line offset bits.
    function automatic logic [ADDR_W_DEF-1:0] to_line_addr(
        input logic [ADDR_W_DEF+OFFSET_W-1:0] word_addr
    );
        return word_addr[ADDR_W_DEF+OFFSET_W-1:OFFSET_W];
    endfunction

endpackage

// File: rtl/line_mem_array.sv
// Backing store: 2**ADDR_W lines of LINE_W bits, synchronous write and
// asynchronous read. Contents are intentionally not reset.
module line_mem_array
    import line_mem_resp_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    // Commit a line on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/line_mem_resp.sv
// Responder end of the cache-line memory handshake (refill read channel and
// writeback write channel) with a programmable latency.
//
// Handshake: a request valid is a level held by the requester until it sees
// the matching one-cycle ready pulse; ready is registered and is high in the
// LATENCY-th cycle after the accepting edge (LATENCY=1: the cycle right after
// acceptance). After the pulse the FSM holds until the valid drops, so a
// held-high valid is served once. Only one transaction is outstanding; a
// same-cycle write wins over a read.
//
// Optional macro LINE_MEM_STAT_EN adds rd_cnt/wr_cnt pulse counters.
module line_mem_resp
    import line_mem_resp_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              r_valid,
    output logic [LINE_W-1:0] r_data,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [LINE_W-1:0] w_data,
    input  logic              w_valid,
    output logic              w_ready,
`ifdef LINE_MEM_STAT_EN
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
`endif
    output state_t            state
);

    state_t            state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] cap_waddr, cap_raddr;
    logic [LINE_W-1:0] cap_wdata;
    logic              cap_w_en, cap_r_en;
    logic              fire_w, fire_r;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;

    // With LATENCY=1 the transaction completes on the accepting edge, so the
    // live inputs (identical to what is being captured) feed the array.
    assign mem_waddr = (state == IDLE) ? w_addr : cap_waddr;
    assign mem_wdata = (state == IDLE) ? w_data : cap_wdata;
    assign mem_raddr = (state == IDLE) ? r_addr : cap_raddr;

    line_mem_array #(
        .LINE_W (LINE_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (fire_w),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Next-state, countdown and completion strobes. fire_* marks the edge that
    // raises the registered ready pulse (the counter reaching zero).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cap_w_en = 1'b0;
        cap_r_en = 1'b0;
        fire_w   = 1'b0;
        fire_r   = 1'b0;
        case (state)
            IDLE: begin
                if (w_valid) begin
                    state_nx = WBUSY;
                    cnt_nx   = CNT_W'(LATENCY - 1);
                    cap_w_en = 1'b1;
                    fire_w   = (LATENCY == 1);
                end else if (r_valid) begin
                    state_nx = RBUSY;
                    cnt_nx   = CNT_W'(LATENCY - 1);
                    cap_r_en = 1'b1;
                    fire_r   = (LATENCY == 1);
                end
            end
            WBUSY: begin
                if (cnt == '0) begin
                    state_nx = WHOLD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                    fire_w = (cnt == CNT_W'(1));
                end
            end
            RBUSY: begin
                if (cnt == '0) begin
                    state_nx = RHOLD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                    fire_r = (cnt == CNT_W'(1));
                end
            end
            WHOLD: begin
                if (!w_valid) begin
                    state_nx = IDLE;
                end
            end
            RHOLD: begin
                if (!r_valid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, counter, capture registers and registered ready/data outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_waddr <= '0;
            cap_raddr <= '0;
            cap_wdata <= '0;
            r_ready   <= 1'b0;
            w_ready   <= 1'b0;
            r_data    <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            r_ready <= fire_r;
            w_ready <= fire_w;
            if (cap_w_en) begin
                cap_waddr <= w_addr;
                cap_wdata <= w_data;
            end
            if (cap_r_en) begin
                cap_raddr <= r_addr;
            end
            if (fire_r) begin
                r_data <= mem_rdata;
            end
        end
    end

`ifdef LINE_MEM_STAT_EN
    // Count served transactions; counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (r_ready) rd_cnt <= rd_cnt + 16'd1;
            if (w_ready) wr_cnt <= wr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/line_mem_resp.md
Name: line_mem_resp

Overview:
- Responder end of the cache-line memory handshake used by the data cache; it serves line refills (read channel) and dirty-line writebacks (write channel).
- Backing store of 2**ADDR_W lines, each LINE_W bits, addressed by line (word address bits [9:2]).
- Models main-memory latency with a programmable cycle count and full valid/ready handshakes.
- Sits between the data cache and nothing else; it is the bottom of the data memory hierarchy.

Parameters:
LINE_W, 128, line width in bits (4 words)
ADDR_W, 8, line address width; depth = 2**ADDR_W = 256 lines
LATENCY, 4, cycles from request acceptance to ready pulse; legal range 1..15

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
r_addr  in  ADDR_W  refill line address
r_valid  in  1  refill request, level, held until r_ready seen
r_data  out  LINE_W  refill line, registered
r_ready  out  1  one-cycle pulse: r_data valid this cycle
w_addr  in  ADDR_W  writeback line address
w_data  in  LINE_W  writeback line
w_valid  in  1  writeback request, level, held until w_ready seen
w_ready  out  1  one-cycle pulse: write committed

Behaviour:
- Reset (async, rstn=0): state IDLE, counter 0, r_ready=0, w_ready=0, r_data=0. Storage array is not reset; simulation initial value is all zero.
- FSM states:
  - IDLE
  - WBUSY
  - RBUSY
  - WHOLD
  - RHOLD
- Request acceptance (IDLE only):
  - If w_valid=1, capture w_addr and w_data, load counter=LATENCY-1, go to WBUSY.
  - Otherwise, if r_valid=1, capture r_addr, load counter=LATENCY-1, go to RBUSY.
  - Write has priority, so a writeback always completes before a same-cycle refill.
- WBUSY:
  - Decrement counter each cycle.
  - When counter==0, write the captured line into the array, pulse w_ready for exactly that cycle, and go to WHOLD.
- RBUSY:
  - Decrement counter each cycle.
  - When counter==0, load r_data from array[captured addr], pulse r_ready for exactly that cycle, and go to RHOLD.
  - r_ready and r_data are registered, so both change on the same edge.
- Latency: if the request is first sampled at edge N, the ready pulse is high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance. LATENCY=1 gives ready in the cycle immediately after acceptance.
- WHOLD/RHOLD: wait until the matching valid is low, then return to IDLE. This prevents a held-high valid from being re-served. A request arriving in the HOLD exit cycle is accepted next cycle from IDLE.
- Channel independence: only one transaction is outstanding at a time. The non-served valid stays pending and is served after return to IDLE.
- Read after write: the write commits before the later read is accepted, so a read to the same line returns the new data with no forwarding path.
- r_data holds its last value between reads. w_ready and r_ready are never high together.
- Captured address/data are used, not live inputs. Input changes after acceptance are ignored until the next acceptance.
- Reset mid-operation: the transaction is aborted, no array write occurs, and outputs return to reset values.
- Address wrap: none; the full ADDR_W range is valid.

Optional Feature:
LINE_MEM_STAT_EN
- Defined: adds outputs rd_cnt[15:0] and wr_cnt[15:0]. Each counter increments on every r_ready or w_ready pulse respectively, wraps 0xFFFF->0, and resets to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WBUSY, RBUSY, WHOLD, RHOLD)
  - LINE_W and ADDR_W defaults shared with the cache
  - constant OFFSET_W=2 for word address to line address conversion
- One sub-module: line_mem_array, a synchronous-write, asynchronous-read 2**ADDR_W x LINE_W array. The FSM, counter and capture registers stay in the top.

Test Plan:
1. Reset, then write w_addr=0x2A, w_data=0x11112222_33334444_55556666_77778888 (LATENCY=4) -> w_ready pulses exactly 4 cycles after acceptance, for 1 cycle; then read 0x2A -> r_ready 4 cycles later with the same data.
2. r_valid and w_valid rise together, w_addr=r_addr=0x10, w_data=0xA5 repeated -> w_ready first; r_ready later (>=LATENCY cycles after w_ready) returning 0xA5 repeated.
3. Hold r_valid high for 10 cycles after r_ready -> exactly one r_ready pulse; after valid drops and is re-raised -> a second pulse.
4. Change w_addr and w_data on the cycle after acceptance -> the originally captured address/data are written; the other line is unchanged.
5. Deassert rstn 2 cycles into a write to line 0x05 (previously 0) -> no ready pulse, outputs 0, state IDLE; a read of 0x05 afterwards returns 0.
6. With LINE_MEM_STAT_EN, 3 writes then 2 reads -> wr_cnt=3, rd_cnt=2. With LATENCY=1, ready arrives 1 cycle after acceptance.
